// File: rtl/debounce_pkg.sv
// Shared helpers for the front-panel input scanners: channel-index sizing and a
// lowest-set-bit priority function over a fixed 32-bit vector.
package debounce_pkg;

  localparam int MAX_CH = 32;

  // Index width for an n-channel scanner; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lowest_set(input logic [MAX_CH-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced channel: polarity, 2-FF synchroniser, settle counter, level and
// press/release pulses. Hold counter for long-press exists only with DEBOUNCE_LONGPRESS_EN.
module debounce_chan #(
  parameter int CNT_W      = 21,
  parameter int ACTIVE_LOW = 0,
  parameter int LONG_W     = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic state,
  output logic press,
  output logic release_o,
  output logic long_press
);

  localparam logic POL = (ACTIVE_LOW != 0);

  logic             x;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  assign x = btn_i ^ POL;

  always_comb begin
    s1_d    = x;
    s2_d    = s1_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    // Any disagreement between the sync stages restarts the settle window.
    if (s1_q != s2_q) begin
      cnt_d = '0;
    end else if (!cnt_q[CNT_W-1]) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cnt_q[CNT_W-1]) state_d = s2_q;
    press_d = ~state_q &  s2_q & cnt_q[CNT_W-1];
    rel_d   =  state_q & ~s2_q & cnt_q[CNT_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign state     = state_q;
  assign press     = press_q;
  assign release_o = rel_q;

`ifdef DEBOUNCE_LONGPRESS_EN
  logic [LONG_W-1:0] h_q, h_d;
  logic              long_q, long_d;

  always_comb begin
    h_d = h_q;
    if (!state_q) begin
      h_d = '0;
    end else if (!h_q[LONG_W-1]) begin
      h_d = h_q + LONG_W'(1);
    end
    // Saturation keeps the MSB high for the rest of the hold, so this fires once.
    long_d = ~h_q[LONG_W-1] & h_d[LONG_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q    <= '0;
      long_q <= 1'b0;
    end else begin
      h_q    <= h_d;
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`else
  logic unused_long_w;
  assign unused_long_w = (LONG_W > 0);
  assign long_press    = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer with a pending-press event queue drained lowest channel first.
// Long-press pulses are generated only when DEBOUNCE_LONGPRESS_EN is defined.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter  int N_CH       = 4,
  parameter  int CNT_W      = 21,
  parameter  int ACTIVE_LOW = 0,
  parameter  int LONG_W     = 27,
  localparam int CH_IDX_W   = ch_idx_w(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     btn,
  output logic [N_CH-1:0]     state,
  output logic [N_CH-1:0]     press,
  // "release" is a reserved word, hence the suffix.
  output logic [N_CH-1:0]     release_o,
  output logic [N_CH-1:0]     long_press,
  output logic                evt_valid,
  output logic [CH_IDX_W-1:0] evt_ch,
  input  logic                evt_ready
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    debounce_chan #(
      .CNT_W     (CNT_W),
      .ACTIVE_LOW(ACTIVE_LOW),
      .LONG_W    (LONG_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .btn_i     (btn[i]),
      .state     (state[i]),
      .press     (press[i]),
      .release_o (release_o[i]),
      .long_press(long_press[i])
    );
  end

  logic [N_CH-1:0]   pend_q, pend_d;
  logic [N_CH-1:0]   clr_mask;
  logic [MAX_CH-1:0] pend_ext;

  always_comb begin
    pend_ext             = '0;
    pend_ext[N_CH-1:0]   = pend_q;
    evt_valid            = |pend_q;
    evt_ch               = CH_IDX_W'(lowest_set(pend_ext));
    clr_mask             = '0;
    if (evt_valid && evt_ready) clr_mask[evt_ch] = 1'b1;
    // Set after clear: a press landing on the channel being accepted is kept.
    pend_d = (pend_q & ~clr_mask) | press;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

endmodule
